bnine_fetch_arbiter: RTL and testbench

Shares one instruction-memory port among NUM_WAYS fetch ways. It generalises the fixed two-way, one-ROM-per-way fetch arrangement to N ways on a single port. Arbitration is round-robin. Up to MAX_OUTSTANDING in-order requests can be in flight, and each response is routed back to the way that issued it. A jump flush discards in-flight responses. Sits between the per-way fetch units and the instruction memory/ROM.

---
 rtl/bnine_fetch_arbiter.sv | 97 +++++++++
 tb/tb_bnine_fetch_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bnine_fetch_arbiter.sv
// bnine_fetch_arbiter: round-robin sharing of one in-order instruction-memory port among NUM_WAYS fetch ways
module bnine_fetch_arbiter #(
  parameter int NUM_WAYS        = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_WAYS-1:0]                way_request_i,
  input  logic [NUM_WAYS*ADDR_W-1:0]         way_instAddr_i,
  output logic [NUM_WAYS-1:0]                way_grant_o,
  output logic [NUM_WAYS-1:0]                way_dataOk_o,
  output logic [DATA_W-1:0]                  way_inst_o,
  input  logic                               jumpFlag_i,
  output logic                               mem_request_o,
  output logic [ADDR_W-1:0]                  mem_instAddr_o,
  input  logic                               mem_ready_i,
  input  logic                               mem_dataOk_i,
  input  logic [DATA_W-1:0]                  mem_inst_i,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_o
);
  localparam int IW = $clog2(NUM_WAYS);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  logic [IW-1:0]       ptr_q, ptr_d, win, idx;
  logic [IW:0]         s;
  logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]       live_q, live_d, stale_q, stale_d, total;
  logic [IW-1:0]       tags_q [MAX_OUTSTANDING];
  logic [NUM_WAYS-1:0] dok_q, dok_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic                err_q, err_d, any, full, fire, pop, live_pop, stale_pop, deliver;
  // scan downward so the lowest offset from the pointer wins
  always_comb begin
    win = '0;
    s   = '0;
    idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      s = {1'b0, ptr_q} + (IW+1)'(i);
      if (s >= (IW+1)'(NUM_WAYS)) s = s - (IW+1)'(NUM_WAYS);
      idx = s[IW-1:0];
      if (way_request_i[idx]) win = idx;
    end
  end
  assign any            = reset_n & |way_request_i;
  assign total          = live_q + stale_q;
  assign full           = total == CW'(MAX_OUTSTANDING);
  assign mem_request_o  = any & ~full & ~jumpFlag_i;
  assign mem_instAddr_o = any ? way_instAddr_i[win*ADDR_W +: ADDR_W] : '0;
  assign fire           = mem_request_o & mem_ready_i;
  assign way_grant_o    = fire ? NUM_WAYS'(1) << win : '0;
  assign pop            = mem_dataOk_i & (total != '0);
  assign stale_pop      = pop & (stale_q != '0);
  assign live_pop       = pop & (stale_q == '0);
  assign deliver        = live_pop & ~jumpFlag_i;
  // a flush turns every surviving live entry stale; stale entries are drained silently
  always_comb begin
    ptr_d   = fire ? ((win == IW'(NUM_WAYS - 1)) ? '0 : win + 1'b1) : ptr_q;
    wr_d    = wr_q + PW'(fire);
    rd_d    = rd_q + PW'(pop);
    stale_d = stale_q - CW'(stale_pop) + (jumpFlag_i ? live_q - CW'(live_pop) : '0);
    live_d  = jumpFlag_i ? '0 : live_q + CW'(fire) - CW'(live_pop);
    dok_d   = deliver ? NUM_WAYS'(1) << tags_q[rd_q] : '0;
    inst_d  = deliver ? mem_inst_i : inst_q;
    err_d   = err_q | (mem_dataOk_i & (total == '0));
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      live_q  <= '0;
      stale_q <= '0;
      dok_q   <= '0;
      inst_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      live_q  <= live_d;
      stale_q <= stale_d;
      dok_q   <= dok_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (fire) tags_q[wr_q] <= win;
  end
  assign way_dataOk_o  = dok_q;
  assign way_inst_o    = inst_q;
  assign outstanding_o = live_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_bnine_fetch_arbiter.sv
// tb_bnine_fetch_arbiter: random and directed stimulus checked against a queue-based reference model
module tb_bnine_fetch_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int CW = $clog2(MO) + 1;
  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req, grant, dok;
  logic [N*AW-1:0] addr;
  logic [DW-1:0] inst, mdat;
  logic          jump, mreq, mready, mdok, err;
  logic [AW-1:0] maddr;
  logic [CW-1:0] outst;
  always #5 clk = ~clk;
  bnine_fetch_arbiter #(.NUM_WAYS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .reset_n(reset_n), .way_request_i(req), .way_instAddr_i(addr),
    .way_grant_o(grant), .way_dataOk_o(dok), .way_inst_o(inst), .jumpFlag_i(jump),
    .mem_request_o(mreq), .mem_instAddr_o(maddr), .mem_ready_i(mready),
    .mem_dataOk_i(mdok), .mem_inst_i(mdat), .outstanding_o(outst), .err_o(err)
  );
  typedef struct {int way; bit stale;} ent_t;
  ent_t          q[$];
  int            rr, n_chk = 0, n_fail = 0, gcount;
  bit            m_err;
  logic [N-1:0]  m_dok, last_grant;
  logic [DW-1:0] m_inst;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void m_reset();
    q.delete();
    rr     = 0;
    m_err  = 0;
    m_dok  = '0;
    m_inst = '0;
  endfunction
  function automatic int live_cnt();
    int c = 0;
    foreach (q[i]) if (!q[i].stale) c++;
    return c;
  endfunction
  // one clock: drive at negedge, check combinational outputs, advance model at posedge, check registers at next negedge
  task automatic step(input logic [N-1:0] r, input bit j, input bit rd, input bit dk, input logic [DW-1:0] d);
    int win;
    bit mr, fire;
    logic [AW-1:0] ea;
    ent_t e;
    req = r; jump = j; mready = rd; mdok = dk; mdat = d;
    for (int k = 0; k < N; k++) addr[k*AW +: AW] = $urandom;
    #1;
    win = -1;
    for (int i = 0; i < N; i++) if (win < 0 && r[(rr + i) % N]) win = (rr + i) % N;
    mr   = (win >= 0) && (q.size() < MO) && !j;
    fire = mr && rd;
    ea   = (win >= 0) ? addr[win*AW +: AW] : '0;
    last_grant = grant;
    check("mem_request", mreq, mr);
    check("mem_addr", maddr, ea);
    check("grant", grant, fire ? (64'd1 << win) : 64'd0);
    @(posedge clk);
    m_dok = '0;
    if (dk) begin
      if (q.size() == 0) m_err = 1;
      else begin
        e = q.pop_front();
        if (!e.stale && !j) begin
          m_dok  = N'(1) << e.way;
          m_inst = d;
        end
      end
    end
    if (j) foreach (q[i]) q[i].stale = 1;
    if (fire) begin
      q.push_back('{way: win, stale: 0});
      rr = (win + 1) % N;
    end
    @(negedge clk);
    check("dataOk", dok, m_dok);
    check("inst", inst, m_inst);
    check("outstanding", outst, live_cnt());
    check("err", err, m_err);
  endtask
  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 20) begin
      step('0, 0, 0, 1, $urandom);
      guard++;
    end
    check("drain_empty", q.size(), 0);
  endtask
  initial begin
    reset_n = 0; req = '0; jump = 0; mready = 0; mdok = 0; mdat = '0; addr = '0;
    m_reset();
    repeat (2) @(negedge clk);
    check("rst_mreq", mreq, 0);
    check("rst_grant", grant, 0);
    check("rst_addr", maddr, 0);
    check("rst_dok", dok, 0);
    check("rst_inst", inst, 0);
    check("rst_outst", outst, 0);
    check("rst_err", err, 0);
    reset_n = 1;
    // two ways streaming with responses trailing two entries behind
    for (int c = 0; c < 12; c++) step(4'b0011, 0, 1, q.size() >= 2, $urandom);
    drain();
    // fill to capacity with no responses
    gcount = 0;
    for (int c = 0; c < 6; c++) begin
      step(4'b1111, 0, 1, 0, $urandom);
      if (last_grant != 0) gcount++;
    end
    check("full_grants", gcount, 4);
    check("full_outst", outst, 4);
    step(4'b1111, 0, 1, 1, $urandom);
    check("pop_no_issue", last_grant, 0);
    check("pop_outst", outst, 3);
    step(4'b1111, 0, 1, 0, $urandom);
    check("issue_resumes", last_grant != 0, 1);
    drain();
    // flush with three in flight
    for (int c = 0; c < 3; c++) step(4'b0001, 0, 1, 0, $urandom);
    step(4'b0010, 1, 1, 0, $urandom);
    check("flush_no_grant", last_grant, 0);
    for (int c = 1; c <= 3; c++) begin
      step('0, 0, 1, 1, 32'hAAAA0000 + c);
      check("stale_no_dok", dok, 0);
    end
    step(4'b0010, 0, 1, 0, $urandom);
    step('0, 0, 1, 1, 32'h1234);
    check("post_flush_inst", inst, 32'h1234);
    check("post_flush_way", dok, 4'b0010);
    // flush coinciding with a live pop
    for (int c = 0; c < 2; c++) step(4'b0100, 0, 1, 0, $urandom);
    step('0, 1, 1, 1, $urandom);
    check("flush_pop_dok", dok, 0);
    check("flush_pop_outst", outst, 0);
    step('0, 0, 1, 1, $urandom);
    check("flush_pop_stale", dok, 0);
    drain();
    // pointer lands at 2, then ways 1 and 3 compete
    step(4'b0010, 0, 1, 0, $urandom);
    step(4'b1010, 0, 1, 0, $urandom);
    check("rr_first_way3", last_grant, 4'b1000);
    step(4'b1010, 0, 1, 0, $urandom);
    check("rr_then_way1", last_grant, 4'b0010);
    drain();
    for (int c = 0; c < 1500; c++)
      step(N'($urandom), $urandom_range(9) == 0, $urandom_range(3) != 0,
           q.size() > 0 && $urandom_range(1) == 1, $urandom);
    // asynchronous reset in the middle of traffic
    for (int c = 0; c < 3; c++) step(4'b1111, 0, 1, 0, $urandom);
    req = 4'b1111; mready = 1; jump = 0; mdok = 0;
    #2 reset_n = 0;
    #1;
    check("arst_mreq", mreq, 0);
    check("arst_grant", grant, 0);
    check("arst_addr", maddr, 0);
    check("arst_dok", dok, 0);
    check("arst_inst", inst, 0);
    check("arst_outst", outst, 0);
    check("arst_err", err, 0);
    m_reset();
    @(negedge clk);
    reset_n = 1;
    step(4'b1111, 0, 1, 0, $urandom);
    check("ptr_after_rst", last_grant, 4'b0001);
    drain();
    // response with nothing outstanding
    step('0, 0, 0, 1, $urandom);
    check("err_set", err, 1);
    check("err_no_dok", dok, 0);
    for (int c = 0; c < 3; c++) step(N'($urandom), 0, 1, 0, $urandom);
    check("err_sticky", err, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
